// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, key map and digit mask.
// Used by keypad_sync and keypad_scanner.
package keypad_pkg;

   typedef enum logic [2:0] {
      SCAN     = 3'd0,
      DEBOUNCE = 3'd1,
      ACCEPT   = 3'd2,
      HOLD     = 3'd3,
      REL_DB   = 3'd4
   } state_t;

   localparam logic [3:0] ROW_IDLE = 4'b1111;

   // Bit {row,col} set where the key is a decimal digit.
   localparam logic [15:0] DIGIT_MASK = 16'b0010_0111_0111_0111;

   // Non-digits: A-D map to their hex value, '*' to 4'hE, '#' to 4'hF.
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'd0:    code = 4'd1;
         4'd1:    code = 4'd2;
         4'd2:    code = 4'd3;
         4'd3:    code = 4'hA;
         4'd4:    code = 4'd4;
         4'd5:    code = 4'd5;
         4'd6:    code = 4'd6;
         4'd7:    code = 4'hB;
         4'd8:    code = 4'd7;
         4'd9:    code = 4'd8;
         4'd10:   code = 4'd9;
         4'd11:   code = 4'hC;
         4'd12:   code = 4'hE;
         4'd13:   code = 4'd0;
         4'd14:   code = 4'hF;
         4'd15:   code = 4'hD;
         default: code = 4'd0;
      endcase
      return code;
   endfunction

   function automatic logic is_digit(input logic [1:0] r, input logic [1:0] c);
      return DIGIT_MASK[{r, c}];
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad column inputs.
// Flops reset to the idle (all released) column pattern.
module keypad_sync
   import keypad_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_d,
   output logic [3:0] o_q
);

   logic [3:0] r_meta;

   // Two-stage capture of the column lines.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= ROW_IDLE;
         o_q    <= ROW_IDLE;
      end else begin
         r_meta <= i_d;
         o_q    <= r_meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce, emitting BCD digits with a shift strobe.
// Optional auto-repeat while a digit is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE_CNT = 20000,
   parameter int REPEAT_CNT   = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [3:0] key,
   output logic       shift,
   output logic       key_down
);

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int CNT_MAX = (REPEAT_CNT > DEBOUNCE_CNT) ? REPEAT_CNT : DEBOUNCE_CNT;
`else
   localparam int CNT_MAX = DEBOUNCE_CNT;
`endif
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam int DW_W  = $clog2(SCAN_DIV);
   localparam logic [DW_W-1:0]  DW_LAST = DW_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CNT);
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CNT - 1);
`endif

   if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 2) begin : g_param_check
      $error("keypad_scanner: illegal parameter value");
   end

   state_t           r_state,  w_state_nx;
   logic [1:0]       r_row_idx, w_row_idx_nx;
   logic [DW_W-1:0]  r_dwell,  w_dwell_nx;
   logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
   logic [3:0]       r_col_pat;
   logic [1:0]       r_col_idx;
   logic [3:0]       w_col_s;
   logic [3:0]       w_col_n;
   logic [1:0]       w_col_enc;
   logic             w_one_low;
   logic             w_digit;
   logic             w_latch;
   logic             w_shift_nx;
   logic             w_kd_set;
   logic             w_kd_clr;

   keypad_sync u_sync (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_d     (col),
      .o_q     (w_col_s)
   );

   // Column decode: exactly-one-low detect and its index.
   always_comb begin
      w_col_n   = ~w_col_s;
      w_one_low = (w_col_n != 4'b0000) && ((w_col_n & (w_col_n - 4'b0001)) == 4'b0000);
      case (w_col_n)
         4'b0001: w_col_enc = 2'd0;
         4'b0010: w_col_enc = 2'd1;
         4'b0100: w_col_enc = 2'd2;
         4'b1000: w_col_enc = 2'd3;
         default: w_col_enc = 2'd0;
      endcase
      w_digit = is_digit(r_row_idx, r_col_idx);
   end

   // Next-state logic; r_cnt is the debounce counter and, in HOLD, the repeat timer.
   always_comb begin
      w_state_nx   = r_state;
      w_row_idx_nx = r_row_idx;
      w_dwell_nx   = r_dwell;
      w_cnt_nx     = r_cnt;
      w_latch      = 1'b0;
      w_shift_nx   = 1'b0;
      w_kd_set     = 1'b0;
      w_kd_clr     = 1'b0;
      case (r_state)
         SCAN: begin
            if (r_dwell == DW_LAST) begin
               w_dwell_nx = '0;
               if (w_one_low) begin
                  w_state_nx = DEBOUNCE;
                  w_cnt_nx   = '0;
                  w_latch    = 1'b1;
               end else begin
                  w_row_idx_nx = r_row_idx + 2'd1;
               end
            end else begin
               w_dwell_nx = r_dwell + DW_W'(1);
            end
         end
         DEBOUNCE: begin
            if (w_col_s != r_col_pat) begin
               w_state_nx = SCAN;
               w_dwell_nx = '0;
            end else if (r_cnt == DB_LAST) begin
               w_state_nx = ACCEPT;
               w_shift_nx = w_digit;
               w_kd_set   = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
         ACCEPT: begin
            // Starting at 1 makes the first repeat land REPEAT_CNT clocks after the accept strobe.
            w_state_nx = HOLD;
            w_cnt_nx   = CNT_W'(1);
         end
         HOLD: begin
            if (w_col_s == ROW_IDLE) begin
               w_state_nx = REL_DB;
               w_cnt_nx   = '0;
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
               if (r_cnt == RP_LAST) begin
                  w_cnt_nx   = '0;
                  w_shift_nx = w_digit;
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
               end
`else
               w_cnt_nx = r_cnt;
`endif
            end
         end
         REL_DB: begin
            if (w_col_s != ROW_IDLE) begin
               w_state_nx = HOLD;
               w_cnt_nx   = '0;
            end else if (r_cnt == DB_LAST) begin
               w_state_nx   = SCAN;
               w_row_idx_nx = r_row_idx + 2'd1;
               w_dwell_nx   = '0;
               w_kd_clr     = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nx = SCAN;
            w_dwell_nx = '0;
            w_cnt_nx   = '0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= SCAN;
         r_row_idx <= 2'd0;
         r_dwell   <= '0;
         r_cnt     <= '0;
         r_col_pat <= ROW_IDLE;
         r_col_idx <= 2'd0;
         row       <= 4'b1110;
         key       <= 4'd0;
         shift     <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_row_idx <= w_row_idx_nx;
         r_dwell   <= w_dwell_nx;
         r_cnt     <= w_cnt_nx;
         row       <= ~(4'b0001 << w_row_idx_nx);
         shift     <= w_shift_nx;
         if (w_latch) begin
            r_col_pat <= w_col_s;
            r_col_idx <= w_col_enc;
         end else begin
            r_col_pat <= r_col_pat;
            r_col_idx <= r_col_idx;
         end
         if (w_shift_nx) begin
            key <= key_code(r_row_idx, r_col_idx);
         end else begin
            key <= key;
         end
         if (w_kd_set) begin
            key_down <= 1'b1;
         end else if (w_kd_clr) begin
            key_down <= 1'b0;
         end else begin
            key_down <= key_down;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, expected-digit scoreboard,
// a table of single presses and hand-written multi-cycle sequences.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 8;
   localparam int RP = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [3:0]  key;
   logic        shift;
   logic        key_down;
   logic [15:0] pressed = 16'h0000;
   logic        prev_shift = 1'b0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [3:0]  exp_q[$];

   typedef struct {
      int         r;
      int         c;
      logic [3:0] key;
      bit         digit;
   } vec_t;

   vec_t vecs[8];

   keypad_scanner #(
      .SCAN_DIV     (SD),
      .DEBOUNCE_CNT (DB),
      .REPEAT_CNT   (RP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .col      (col),
      .row      (row),
      .key      (key),
      .shift    (shift),
      .key_down (key_down)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Keypad matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      col = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_kd(input logic level, input int budget, input string name);
      int n = 0;
      while (key_down !== level && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, key_down, level);
   endtask

   task automatic wait_shift(input int budget, input string name, output int n);
      n = 0;
      while (shift !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, shift, 1'b1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_row"}, row, 4'b1110);
      check({tag, "_key"}, key, 4'd0);
      check({tag, "_shift"}, shift, 1'b0);
      check({tag, "_key_down"}, key_down, 1'b0);
   endtask

   // Scoreboard: every shift must match the next expected digit; shift never back-to-back.
   always @(negedge clk) begin
      if (reset) begin
         if (shift) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_shift: got key %0h with no digit expected (t=%0t)", key, $time);
            end else begin
               check("shift_key", key, exp_q.pop_front());
            end
            check("shift_not_back_to_back", prev_shift, 1'b0);
         end
         prev_shift <= shift;
      end else begin
         prev_shift <= 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] row_seq[5];
      int n;
      int kd_hits;
      int t0;

      vecs[0] = '{r: 1, c: 1, key: 4'd5, digit: 1'b1};
      vecs[1] = '{r: 0, c: 0, key: 4'd1, digit: 1'b1};
      vecs[2] = '{r: 2, c: 2, key: 4'd9, digit: 1'b1};
      vecs[3] = '{r: 3, c: 1, key: 4'd0, digit: 1'b1};
      vecs[4] = '{r: 1, c: 2, key: 4'd6, digit: 1'b1};
      vecs[5] = '{r: 0, c: 3, key: 4'd6, digit: 1'b0};
      vecs[6] = '{r: 3, c: 0, key: 4'd6, digit: 1'b0};
      vecs[7] = '{r: 3, c: 3, key: 4'd6, digit: 1'b0};
      row_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

      // 1. reset values and idle row rotation
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("row_cycle", row, row_seq[i]);
         repeat (SD) @(negedge clk);
      end

      // table of single presses
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].digit) exp_q.push_back(vecs[i].key);
         pressed = 16'h0000;
         pressed[vecs[i].r*4 + vecs[i].c] = 1'b1;
         wait_kd(1'b1, 200, "tbl_kd_rise");
         repeat (10) @(negedge clk);
         check("tbl_key", key, vecs[i].key);
         pressed = 16'h0000;
         wait_kd(1'b0, 100, "tbl_kd_fall");
         repeat (5) @(negedge clk);
         check("tbl_queue_drained", exp_q.size(), 0);
      end

      // 2. r1c1: key_down survives the release debounce window, single shift
      exp_q.push_back(4'd5);
      pressed = 16'h0020;
      wait_kd(1'b1, 200, "t2_kd_rise");
      repeat (20) @(negedge clk);
      pressed = 16'h0000;
      repeat (DB) @(negedge clk);
      check("t2_kd_after_release", key_down, 1'b1);
      wait_kd(1'b0, 10, "t2_kd_fall");
      repeat (40) @(negedge clk);
      check("t2_single_shift", exp_q.size(), 0);

      // 3. bouncing r2c2 never debounces, then a stable press gives 9
      kd_hits = 0;
      for (int t = 0; t < 12; t++) begin
         pressed = (t % 2 == 0) ? 16'h0400 : 16'h0000;
         repeat (5) begin
            @(negedge clk);
            if (key_down) kd_hits++;
         end
      end
      check("t3_bounce_no_keydown", kd_hits, 0);
      exp_q.push_back(4'd9);
      pressed = 16'h0400;
      wait_kd(1'b1, 200, "t3_kd_rise");
      check("t3_key", key, 4'd9);
      pressed = 16'h0000;
      wait_kd(1'b0, 100, "t3_kd_fall");

      // 4. non-digit 'A' after 5: key_down but key unchanged, no shift
      exp_q.push_back(4'd5);
      pressed = 16'h0020;
      wait_kd(1'b1, 200, "t4_kd_rise_5");
      pressed = 16'h0000;
      wait_kd(1'b0, 100, "t4_kd_fall_5");
      pressed = 16'h0008;
      wait_kd(1'b1, 200, "t4_kd_rise_A");
      repeat (10) @(negedge clk);
      check("t4_key_kept", key, 4'd5);
      pressed = 16'h0000;
      wait_kd(1'b0, 100, "t4_kd_fall_A");
      check("t4_no_shift", exp_q.size(), 0);

      // 5. ghosted double press ignored, then r3c1 gives 0
      kd_hits = 0;
      pressed = 16'h0300;
      repeat (100) begin
         @(negedge clk);
         if (key_down) kd_hits++;
      end
      check("t5_ghost_no_keydown", kd_hits, 0);
      pressed = 16'h0000;
      repeat (5) @(negedge clk);
      exp_q.push_back(4'd0);
      pressed = 16'h2000;
      wait_kd(1'b1, 200, "t5_kd_rise");
      check("t5_key", key, 4'd0);
      pressed = 16'h0000;
      wait_kd(1'b0, 100, "t5_kd_fall");

      // 6. reset in HOLD with 7 held; re-detected as a fresh press
      exp_q.push_back(4'd7);
      pressed = 16'h0100;
      wait_kd(1'b1, 200, "t6_kd_rise");
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_vals("t6_async");
      repeat (2) @(negedge clk);
      check_reset_vals("t6_held");
      reset = 1'b1;
      exp_q.push_back(4'd7);
      wait_shift(200, "t6_reshift", n);
      check("t6_key", key, 4'd7);
      pressed = 16'h0000;
      wait_kd(1'b0, 100, "t6_kd_fall");
      check("t6_queue_drained", exp_q.size(), 0);

      // latency: r0c0 held through reset, first sample on the SD-th clock, shift DB+1 clocks later
      pressed = 16'h0001;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      exp_q.push_back(4'd1);
      wait_shift(100, "lat_shift", n);
      check("lat_cycles", n, SD + DB + 1);
      pressed = 16'h0000;
      wait_kd(1'b0, 100, "lat_kd_fall");

`ifdef KEYPAD_AUTOREPEAT_EN
      // 7. auto-repeat on r0c0 every RP clocks
      repeat (4) exp_q.push_back(4'd1);
      pressed = 16'h0001;
      wait_shift(200, "t7_first", n);
      t0 = cyc;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         wait_shift(RP + 5, "t7_repeat", n);
         check("t7_period", cyc - t0, RP * k);
      end
      repeat (10) @(negedge clk);
      pressed = 16'h0000;
      wait_kd(1'b0, 100, "t7_kd_fall");
      check("t7_four_shifts", exp_q.size(), 0);
`else
      t0 = 0;
`endif

      repeat (20) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
